// File: rtl/mips_mem_pkg.sv
// Shared memory-side types for the MEM stage: word, word address and store-buffer entry.
// Pure declarations, no logic, no latency, no backpressure.
package mips_mem_pkg;
    localparam int MEM_ADDR_W = 32;
    localparam int MEM_DATA_W = 32;
    localparam int SB_DEPTH   = 4;

    typedef logic [MEM_DATA_W-1:0] word_t;
    typedef logic [MEM_ADDR_W-3:0] waddr_t;

    typedef struct packed {
        waddr_t waddr;
        word_t  data;
    } sb_entry_t;
endpackage

// File: rtl/sb_fifo_ctrl.sv
// Head/tail/count bookkeeping for the store buffer; updates one cycle after push/pop.
// The caller gates push with full, so full and empty are plain state decodes.
module sb_fifo_ctrl #(
    parameter int DEPTH = 4,
    localparam int PW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    output logic [PW-1:0] head,
    output logic [PW-1:0] tail,
    output logic [PW:0]   count,
    output logic          full,
    output logic          empty
);
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + PW'(1);
            if (pop)  head <= head + PW'(1);
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end

    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);
endmodule

// File: rtl/store_buffer.sv
// Store buffer owning the data_memory port: stores retire in one cycle, loads forward same-cycle,
// drains one word per non-load cycle; only a full buffer deasserts cpu_ready. Option: STORE_COALESCE_EN.
module store_buffer
    import mips_mem_pkg::*;
#(
    parameter int DEPTH  = SB_DEPTH,
    parameter int ADDR_W = MEM_ADDR_W,
    parameter int DATA_W = MEM_DATA_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cpu_valid,
    input  logic                     cpu_we,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [DATA_W-1:0]        cpu_wdata,
    output logic                     cpu_ready,
    output logic [DATA_W-1:0]        cpu_rdata,
    output logic [ADDR_W-1:0]        mem_a,
    output logic                     mem_we,
    output logic [DATA_W-1:0]        mem_wd,
    input  logic [DATA_W-1:0]        mem_rd,
    output logic                     sb_empty,
    output logic [$clog2(DEPTH):0]   sb_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int WW = ADDR_W - 2;

    typedef struct packed {
        logic [WW-1:0]     waddr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t            ent [DEPTH];
    logic [PW-1:0]     head, tail, idx;
    logic [PW:0]       count;
    logic              full, empty;
    logic              is_load, is_store, drain, coalesce, push;
    logic              fwd_hit;
    logic [DATA_W-1:0] fwd_data;
    logic [WW-1:0]     cpu_waddr;
    logic              unused_byte_off;

    assign cpu_waddr       = cpu_addr[ADDR_W-1:2];
    assign unused_byte_off = ^cpu_addr[1:0];
    assign is_load         = cpu_valid && !cpu_we;
    assign is_store        = cpu_valid && cpu_we;
    // Loads own the port; the head drains only on cycles without one.
    assign drain           = !empty && !is_load;

`ifdef STORE_COALESCE_EN
    logic [PW-1:0] youngest;
    assign youngest = tail - PW'(1);
    assign coalesce = is_store && !empty && (ent[youngest].waddr == cpu_waddr)
                      && !((youngest == head) && drain);
`else
    assign coalesce = 1'b0;
`endif

    assign cpu_ready = !is_store || coalesce || !full;
    assign push      = is_store && !full && !coalesce;

    sb_fifo_ctrl #(.DEPTH(DEPTH)) u_ctrl (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (drain),
        .head  (head),
        .tail  (tail),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk) begin
        if (push) ent[tail] <= '{waddr: cpu_waddr, data: cpu_wdata};
`ifdef STORE_COALESCE_EN
        if (coalesce) ent[youngest].data <= cpu_wdata;
`endif
    end

    // Walk oldest to youngest so the last hit is the youngest matching store.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        idx      = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (((PW+1)'(i) < count) && (ent[idx].waddr == cpu_waddr)) begin
                fwd_hit  = 1'b1;
                fwd_data = ent[idx].data;
            end
        end
    end

    assign cpu_rdata = (is_load && fwd_hit) ? fwd_data : mem_rd;

    always_comb begin
        mem_a  = '0;
        mem_we = 1'b0;
        mem_wd = '0;
        if (is_load) begin
            mem_a = cpu_addr;
        end else if (drain) begin
            mem_a  = {ent[head].waddr, 2'b00};
            mem_wd = ent[head].data;
            mem_we = !rst;
        end
    end

    assign sb_count = count;
    assign sb_empty = empty;
endmodule

// File: tb/tb_store_buffer.sv
// Randomized scoreboard bench for store_buffer against a queue-based model of pending stores.
module tb_store_buffer;
    localparam int DEPTH = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_valid, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata, cpu_rdata;
    logic          cpu_ready;
    logic [AW-1:0] mem_a;
    logic          mem_we;
    logic [DW-1:0] mem_wd, mem_rd;
    logic          sb_empty;
    logic [2:0]    sb_count;

    always #5 clk = ~clk;

    store_buffer #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_valid (cpu_valid),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_ready (cpu_ready),
        .cpu_rdata (cpu_rdata),
        .mem_a     (mem_a),
        .mem_we    (mem_we),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd),
        .sb_empty  (sb_empty),
        .sb_count  (sb_count)
    );

    function automatic logic [31:0] init_val(input int i);
        return (32'h9E37_79B9 * i) ^ 32'hA5A5_0000;
    endfunction

    // Environment data_memory (64 words)
    logic [31:0] env_mem [64];
    logic        mem_init;
    assign mem_rd = env_mem[mem_a[7:2]];
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 64; i++) env_mem[i] <= init_val(i);
        end else if (mem_we) begin
            env_mem[mem_a[7:2]] <= mem_wd;
        end
    end

    // Reference model: pending stores in program order, plus memory image
    typedef struct { logic [5:0] w; logic [31:0] d; } st_t;
    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    st_t         sbq[$];
    wr_t         wexp[$];
    logic [31:0] lexp[$];
    logic [31:0] ref_mem [64];

    int total = 0;
    int bad   = 0;
    bit known = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            if (wexp.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got a=%h d=%h expected no write", mem_a, mem_wd);
            end else begin
                wr_t e;
                e = wexp.pop_front();
                check("write_addr", mem_a, e.a);
                check("write_data", mem_wd, e.d);
            end
        end
        if (cpu_valid && !cpu_we && lexp.size() > 0) begin
            check("load_rdata", cpu_rdata, lexp.pop_front());
        end
    end

    task automatic step(input bit r, input bit v, input bit w, input logic [7:0] a, input logic [31:0] d);
        int          pre;
        bit          load, store, drn, co, exp_rdy;
        logic [31:0] ld;
        @(posedge clk);
        #1;
        rst = r; cpu_valid = v; cpu_we = w; cpu_addr = {24'h0, a}; cpu_wdata = d;
        pre   = sbq.size();
        load  = v && !w;
        store = v && w;
        drn   = (pre > 0) && !load;
        co    = 1'b0;
`ifdef STORE_COALESCE_EN
        if (store && pre > 0 && sbq[pre-1].w == a[7:2] && !(pre == 1 && drn)) co = 1'b1;
`endif
        exp_rdy = !store || co || (pre < DEPTH);
        if (load) begin
            ld = ref_mem[a[7:2]];
            foreach (sbq[i]) if (sbq[i].w == a[7:2]) ld = sbq[i].d;
            lexp.push_back(ld);
        end
        if (r) begin
            sbq.delete();
        end else begin
            if (drn) begin
                wexp.push_back('{{24'h0, sbq[0].w, 2'b00}, sbq[0].d});
                ref_mem[sbq[0].w] = sbq[0].d;
                void'(sbq.pop_front());
            end
            if (co) sbq[$].d = d;
            else if (store && exp_rdy) sbq.push_back('{a[7:2], d});
        end
        @(negedge clk);
        check("cpu_ready", {31'b0, cpu_ready}, {31'b0, exp_rdy});
        if (known) begin
            check("sb_count", {29'b0, sb_count}, 32'(pre));
            check("sb_empty", {31'b0, sb_empty}, {31'b0, pre == 0});
        end
        if (r) begin
            check("mem_we_in_rst", {31'b0, mem_we}, 32'h0);
            known = 1;
        end
    endtask

    task automatic idle();
        step(0, 0, 0, 8'h00, 32'h0);
    endtask

    initial begin
        int p;
        rst = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        mem_init = 1'b1;
        for (int i = 0; i < 64; i++) ref_mem[i] = init_val(i);
        step(1, 0, 0, 8'h00, 32'h0);
        step(1, 0, 0, 8'h00, 32'h0);
        mem_init = 1'b0;

        // single store on idle port, drained the next cycle
        step(0, 1, 1, 8'h10, 32'hDEADBEEF);
        idle(); idle();
        // forwarding to a load at a byte offset in the same word
        step(0, 1, 1, 8'h20, 32'h1111_1111);
        step(0, 1, 0, 8'h22, 32'h0);
        idle();
        // same word stored twice around loads; program order kept in memory
        step(0, 1, 1, 8'h40, 32'h1);
        step(0, 1, 0, 8'h44, 32'h0);
        step(0, 1, 1, 8'h40, 32'h2);
        step(0, 1, 0, 8'h40, 32'h0);
        idle(); idle();
        step(0, 1, 0, 8'h40, 32'h0);
        // reset with a pending store discards it
        step(0, 1, 0, 8'h08, 32'h0);
        step(0, 1, 1, 8'h30, 32'hCAFE_F00D);
        step(0, 1, 0, 8'h30, 32'h0);
        step(1, 0, 0, 8'h00, 32'h0);
        idle();
        step(0, 1, 0, 8'h30, 32'h0);

        repeat (600) begin
            p = $urandom_range(0, 99);
            if (p < 2)       step(1, 0, 0, 8'h0, 32'h0);
            else if (p < 45) step(0, 1, 0, 8'($urandom_range(0, 63)), 32'h0);
            else if (p < 85) step(0, 1, 1, 8'($urandom_range(0, 63)), $urandom);
            else             idle();
        end
        repeat (DEPTH + 4) idle();
        check("writes_outstanding", 32'(wexp.size()), 32'h0);
        check("loads_outstanding", 32'(lexp.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
